// File: rtl/reg_move_sequencer.sv
// MOV8 register-to-register move sequencer: decodes 00_ddd_sss and drives one-hot
// bus-select / load strobes with setup, load and hold phases, plus a busy/done handshake.
module reg_move_sequencer #(
  parameter int SETUP_CYC = 2,
  parameter int LOAD_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic [7:0] sel,
  output logic [7:0] load,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      dst_q;
  logic [7:0]      sel_q;
  logic [7:0]      load_q;
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;

  logic            is_mov_d;
  logic [7:0]      src_sel_d;

  // A move with dst==src leaves the bus undriven so the destination is cleared.
  always_comb begin
    is_mov_d  = (instr[7:6] == 2'b00);
    src_sel_d = (instr[5:3] == instr[2:0]) ? 8'h00 : (8'h01 << instr[2:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dst_q     <= '0;
      sel_q     <= '0;
      load_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_mov_d) begin
              state_q <= SETUP;
              cnt_q   <= CW'(SETUP_CYC - 1);
              dst_q   <= instr[5:3];
              sel_q   <= src_sel_d;
              busy_q  <= 1'b1;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= LOAD;
            cnt_q   <= CW'(LOAD_CYC - 1);
            load_q  <= 8'h01 << dst_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LOAD: begin
          if (cnt_q == '0) begin
            state_q <= HOLD;
            cnt_q   <= CW'(HOLD_CYC - 1);
            load_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            cnt_q   <= '0;
            sel_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // busy stays high through the done cycle, so start is ignored here.
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          sel_q   <= '0;
          load_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign load    = load_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Self-checking bench for reg_move_sequencer: directed scenarios, a full MOV8 sweep and
// random traffic, all compared every cycle against a cycle-offset reference model.
module tb_reg_move_sequencer;

  localparam int S = 2;
  localparam int L = 2;
  localparam int H = 1;
  localparam int D = S + L + H + 1;   // cycle index of the done pulse

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [7:0] sel, load;
  logic       busy, done, illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a move is described by the number of edges since it was accepted.
  bit         m_active = 0;
  int         m_t = 0;
  int         m_src = 0;
  int         m_dst = 0;
  bit         m_ill = 0;

  reg_move_sequencer #(.SETUP_CYC(S), .LOAD_CYC(L), .HOLD_CYC(H)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .sel(sel), .load(load), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    int c;
    logic [7:0] e_sel, e_load;
    logic e_busy, e_done;
    c = m_t + 1;
    e_sel  = 8'h00;
    e_load = 8'h00;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (m_active) begin
      if (c >= 1 && c <= S + L + H && m_src != m_dst) e_sel = 8'h01 << m_src;
      if (c >= S + 1 && c <= S + L) e_load = 8'h01 << m_dst;
      e_busy = (c >= 1 && c <= D);
      e_done = (c == D);
    end
    chk("sel", sel, e_sel);
    chk("load", load, e_load);
    chk("busy", {7'd0, busy}, {7'd0, e_busy});
    chk("done", {7'd0, done}, {7'd0, e_done});
    chk("illegal", {7'd0, illegal}, {7'd0, m_ill});
    chk("sel_onehot0", {7'd0, $onehot0(sel)}, 8'h01);
    chk("load_onehot0", {7'd0, $onehot0(load)}, 8'h01);
    chk("done_illegal_excl", {7'd0, done & illegal}, 8'h00);
  endtask

  // Drive one clock cycle's inputs, advance the model across the edge, then check.
  task automatic step(input logic rst, input logic st, input logic [7:0] ins);
    reset = rst;
    start = st;
    instr = ins;
    @(posedge clk);
    m_ill = 0;
    if (rst) begin
      m_active = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t + 1 > D) m_active = 0;
    end else if (st) begin
      if (ins[7:6] == 2'b00) begin
        m_active = 1;
        m_t = 0;
        m_dst = int'(ins[5:3]);
        m_src = int'(ins[2:0]);
        $display("cycle %0d: move instr=%h src=%0d dst=%0d", cyc, ins, m_src, m_dst);
      end else begin
        m_ill = 1;
        $display("cycle %0d: illegal instr=%h", cyc, ins);
      end
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 255));
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h01);

    // B->A
    step(1'b0, 1'b1, 8'h01);
    idle(8);

    // Y->Y clear idiom
    step(1'b0, 1'b1, 8'h3F);
    idle(8);

    // Illegal byte, then C->B
    step(1'b0, 1'b1, 8'h41);
    idle(2);
    step(1'b0, 1'b1, 8'h0A);
    idle(8);

    // start held high: moves accepted only every D+1 cycles
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h11);
    idle(8);

    // Reset mid-move A->M2
    step(1'b0, 1'b1, 8'h28);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(8);

    // Sweep all MOV8 encodings, with instr scrambled during the move
    for (int k = 0; k < 64; k++) begin
      step(1'b0, 1'b1, 8'(k));
      for (int j = 0; j < D; j++) step(1'b0, 1'b1, $urandom_range(0, 255));
      step(1'b0, 1'b0, 8'h00);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) r[7:6] = 2'b00;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), r);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
